// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard/forwarding unit: stage records and forward selects.
package pipe_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
  } stage_rec_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  // True when the record will write the given architectural register.
  function automatic logic rec_writes(stage_rec_t rec, logic [REG_ADDR_W-1:0] addr);
    return rec.valid && rec.reg_write && (rec.rd == addr);
  endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// Forward select for one EX operand: MEM result wins over WB, x0 never forwards.
module pipe_fwd_sel
  import pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src_addr_i,
  input  logic                  src_used_i,
  input  stage_rec_t            mem_rec_i,
  input  stage_rec_t            wb_rec_i,
  output fwd_sel_e              sel_o
);

  logic unused_is_load;
  assign unused_is_load = mem_rec_i.is_load ^ wb_rec_i.is_load;

  always_comb begin
    sel_o = FWD_RF;
    if (src_used_i && (src_addr_i != '0)) begin
      if (rec_writes(mem_rec_i, src_addr_i)) begin
        sel_o = FWD_MEM;
      end else if (rec_writes(wb_rec_i, src_addr_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage pipe: load-use stall, redirect flush, freeze.
// Optional perf counters are built when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_unit #(
  parameter int unsigned X_LEN       = 32,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned FWD_DEPTH   = 3,
  parameter int unsigned FLUSH_SLOTS = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
  input  logic                  id_reg_write_i,
  input  logic                  id_is_load_i,
  input  logic                  ex_redirect_i,
  input  logic                  mem_wait_i,
  output logic                  stall_if_o,
  output logic                  stall_id_o,
  output logic                  flush_id_o,
  output logic                  bubble_ex_o,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [X_LEN-1:0]      perf_stall_cnt_o,
  output logic [X_LEN-1:0]      perf_flush_cnt_o
`endif
);
  import pipe_pkg::*;

  if (FLUSH_SLOTS < 1 || FLUSH_SLOTS > 3 || (FWD_DEPTH != 2 && FWD_DEPTH != 3) ||
      REG_ADDR_W != pipe_pkg::REG_ADDR_W || X_LEN == 0) begin : g_bad_param
    $fatal(1, "pipe_hazard_unit: unsupported parameter set");
  end

  localparam logic [1:0] FlushLoad = 2'(FLUSH_SLOTS - 1);

  stage_rec_t            id_rec, ex_rec_q, mem_rec_q, wb_rec;
  logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs2_q;
  logic                  ex_rs1_used_q, ex_rs2_used_q;
  logic [1:0]            flush_cnt_q, flush_cnt_d;
  logic                  run, load_use, bubble;
  fwd_sel_e              fwd_a, fwd_b;

  assign run = !mem_wait_i;

  assign id_rec.valid     = id_valid_i;
  assign id_rec.rd        = id_rd_addr_i;
  assign id_rec.reg_write = id_reg_write_i && (id_rd_addr_i != '0);
  assign id_rec.is_load   = id_is_load_i;

  assign load_use = id_valid_i && ex_rec_q.valid && ex_rec_q.is_load && ex_rec_q.reg_write &&
                    ((id_rs1_used_i && (id_rs1_addr_i == ex_rec_q.rd)) ||
                     (id_rs2_used_i && (id_rs2_addr_i == ex_rec_q.rd)));

  assign bubble = run && (ex_redirect_i || load_use);

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (run) begin
      if (ex_redirect_i) begin
        flush_cnt_d = FlushLoad;
      end else if (flush_cnt_q != '0) begin
        flush_cnt_d = flush_cnt_q - 2'd1;
      end
    end
  end

  // EX sources are captured even for bubbles so a held consumer sees its producer in MEM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_rec_q      <= '0;
      mem_rec_q     <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rs1_used_q <= 1'b0;
      ex_rs2_used_q <= 1'b0;
      flush_cnt_q   <= '0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      if (run) begin
        ex_rec_q      <= (bubble || !id_valid_i) ? '0 : id_rec;
        mem_rec_q     <= ex_rec_q;
        ex_rs1_q      <= id_rs1_addr_i;
        ex_rs2_q      <= id_rs2_addr_i;
        ex_rs1_used_q <= id_rs1_used_i;
        ex_rs2_used_q <= id_rs2_used_i;
      end
    end
  end

  if (FWD_DEPTH >= 3) begin : g_wb
    stage_rec_t wb_rec_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wb_rec_q <= '0;
      end else if (run) begin
        wb_rec_q <= mem_rec_q;
      end
    end
    assign wb_rec = wb_rec_q;
  end else begin : g_no_wb
    // Regfile writes through, so WB never needs a forward path.
    assign wb_rec = '0;
  end

  pipe_fwd_sel u_fwd_a (
    .src_addr_i (ex_rs1_q),
    .src_used_i (ex_rs1_used_q),
    .mem_rec_i  (mem_rec_q),
    .wb_rec_i   (wb_rec),
    .sel_o      (fwd_a)
  );

  pipe_fwd_sel u_fwd_b (
    .src_addr_i (ex_rs2_q),
    .src_used_i (ex_rs2_used_q),
    .mem_rec_i  (mem_rec_q),
    .wb_rec_i   (wb_rec),
    .sel_o      (fwd_b)
  );

  assign stall_if_o  = rst_ni && (!run || (load_use && !ex_redirect_i));
  assign stall_id_o  = stall_if_o;
  assign flush_id_o  = rst_ni && run && (ex_redirect_i || (flush_cnt_q != '0));
  assign bubble_ex_o = rst_ni && bubble;
  assign fwd_a_o     = rst_ni ? fwd_a : FWD_RF;
  assign fwd_b_o     = rst_ni ? fwd_b : FWD_RF;

`ifdef PIPE_HAZARD_PERF_EN
  logic [X_LEN-1:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (run && load_use && !ex_redirect_i && !(&perf_stall_q)) begin
        perf_stall_q <= perf_stall_q + X_LEN'(1);
      end
      if (run && ex_redirect_i && !(&perf_flush_q)) begin
        perf_flush_q <= perf_flush_q + X_LEN'(1);
      end
    end
  end

  assign perf_stall_cnt_o = perf_stall_q;
  assign perf_flush_cnt_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed vector table, reset corner, then random vs reference model.
module tb_pipe_hazard_unit;

  localparam int unsigned XLen       = 32;
  localparam int unsigned RegW       = 5;
  localparam int unsigned FwdDepth   = 3;
  localparam int unsigned FlushSlots = 2;
  localparam int unsigned NumRand    = 3000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            id_valid, rs1_used, rs2_used, reg_write, is_load, redirect, mem_wait;
  logic [RegW-1:0] rs1, rs2, rd;
  logic            stall_if, stall_id, flush_id, bubble_ex;
  logic [1:0]      fwd_a, fwd_b;
`ifdef PIPE_HAZARD_PERF_EN
  logic [XLen-1:0] perf_stall, perf_flush;
`endif

  pipe_hazard_unit #(
    .X_LEN       (XLen),
    .REG_ADDR_W  (RegW),
    .FWD_DEPTH   (FwdDepth),
    .FLUSH_SLOTS (FlushSlots)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .id_valid_i     (id_valid),
    .id_rs1_addr_i  (rs1),
    .id_rs2_addr_i  (rs2),
    .id_rs1_used_i  (rs1_used),
    .id_rs2_used_i  (rs2_used),
    .id_rd_addr_i   (rd),
    .id_reg_write_i (reg_write),
    .id_is_load_i   (is_load),
    .ex_redirect_i  (redirect),
    .mem_wait_i     (mem_wait),
    .stall_if_o     (stall_if),
    .stall_id_o     (stall_id),
    .flush_id_o     (flush_id),
    .bubble_ex_o    (bubble_ex),
    .fwd_a_o        (fwd_a),
    .fwd_b_o        (fwd_b)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .perf_stall_cnt_o (perf_stall),
    .perf_flush_cnt_o (perf_flush)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v; logic [RegW-1:0] rs1; logic [RegW-1:0] rs2; logic u1; logic u2;
    logic [RegW-1:0] rd; logic we; logic ld; logic redir; logic mw;
  } in_t;

  typedef struct { in_t in; logic [7:0] exp; } vec_t;

  // In-flight instruction as seen by the reference model (index 0 = EX).
  typedef struct packed { logic valid; logic [RegW-1:0] rd; logic wr; logic ld; } mrec_t;

  vec_t            tbl[$];
  int              total = 0;
  int              bad = 0;
  mrec_t           m_pipe[FwdDepth];
  logic [RegW-1:0] m_src[2];
  logic            m_used[2];
  int              m_flush_left;
  int              m_stall_cnt, m_flush_cnt;

  function automatic in_t mk(logic v, int a, int b, logic u1, logic u2, int d, logic we,
                             logic ld, logic redir, logic mw);
    in_t x;
    x.v = v; x.rs1 = RegW'(a); x.rs2 = RegW'(b); x.u1 = u1; x.u2 = u2; x.rd = RegW'(d);
    x.we = we; x.ld = ld; x.redir = redir; x.mw = mw;
    return x;
  endfunction

  function automatic void add(in_t x, logic [7:0] exp);
    vec_t e;
    e.in = x; e.exp = exp;
    tbl.push_back(e);
  endfunction

  task automatic drive(input in_t x);
    id_valid = x.v; rs1 = x.rs1; rs2 = x.rs2; rs1_used = x.u1; rs2_used = x.u2;
    rd = x.rd; reg_write = x.we; is_load = x.ld; redirect = x.redir; mem_wait = x.mw;
  endtask

  // Expected packing: {stall_if, stall_id, flush_id, bubble_ex, fwd_a, fwd_b}.
  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = {stall_if, stall_id, flush_id, bubble_ex, fwd_a, fwd_b};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  function automatic logic [1:0] m_fwd(int op);
    if (!m_used[op] || m_src[op] == '0) return 2'b00;
    for (int s = 1; s < FwdDepth; s++) begin
      if (m_pipe[s].valid && m_pipe[s].wr && m_pipe[s].rd == m_src[op]) return 2'(s);
    end
    return 2'b00;
  endfunction

  function automatic logic m_hazard(in_t x);
    return x.v && m_pipe[0].valid && m_pipe[0].ld && m_pipe[0].wr &&
           ((x.u1 && x.rs1 == m_pipe[0].rd) || (x.u2 && x.rs2 == m_pipe[0].rd));
  endfunction

  function automatic logic [7:0] m_expect(in_t x);
    logic hz, st, fl, bb;
    hz = m_hazard(x);
    if (x.mw) begin
      st = 1'b1; fl = 1'b0; bb = 1'b0;
    end else begin
      st = hz && !x.redir;
      fl = x.redir || (m_flush_left > 0);
      bb = x.redir || hz;
    end
    return {st, st, fl, bb, m_fwd(0), m_fwd(1)};
  endfunction

  function automatic void m_step(in_t x);
    logic hz;
    if (x.mw) return;
    hz = m_hazard(x);
    if (hz && !x.redir) m_stall_cnt++;
    if (x.redir) m_flush_cnt++;
    for (int s = FwdDepth - 1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
    if (x.redir || hz || !x.v) m_pipe[0] = '0;
    else m_pipe[0] = '{valid: 1'b1, rd: x.rd, wr: x.we && (x.rd != '0), ld: x.ld};
    m_src[0] = x.rs1; m_src[1] = x.rs2; m_used[0] = x.u1; m_used[1] = x.u2;
    if (x.redir) m_flush_left = int'(FlushSlots) - 1;
    else if (m_flush_left > 0) m_flush_left--;
  endfunction

  initial begin
    in_t idle, x;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // add/sub forwarding through MEM then WB
    add(idle,                                  8'h00);
    add(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0),      8'h00);  // add x5,x1,x2
    add(mk(1, 5, 3, 1, 1, 6, 1, 0, 0, 0),      8'h00);  // sub x6,x5,x3
    add(mk(1, 5, 4, 1, 1, 10, 1, 0, 0, 0),     8'h04);  // sub in EX: a from MEM
    add(idle,                                  8'h08);  // or in EX: x5 from WB
    // lw x7 then add x8,x7,x7
    add(mk(1, 1, 0, 1, 0, 7, 1, 1, 0, 0),      8'h00);
    add(mk(1, 7, 7, 1, 1, 8, 1, 0, 0, 0),      8'hD0);
    add(mk(1, 7, 7, 1, 1, 8, 1, 0, 0, 0),      8'h05);
    add(idle,                                  8'h0A);
    // x0 destinations never forward or stall
    add(mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0),      8'h00);
    add(mk(1, 0, 0, 1, 1, 9, 1, 0, 0, 0),      8'h00);
    add(mk(1, 1, 0, 1, 0, 0, 1, 1, 0, 0),      8'h00);
    add(mk(1, 0, 0, 1, 1, 11, 1, 0, 0, 0),     8'h00);
    // load-use coincident with redirect, two flush slots
    add(mk(1, 2, 0, 1, 0, 12, 1, 1, 0, 0),     8'h00);
    add(mk(1, 12, 0, 1, 1, 13, 1, 0, 1, 0),    8'h30);
    add(idle,                                  8'h24);
    add(idle,                                  8'h00);
    // three frozen cycles with a MEM forward pending
    add(mk(1, 3, 4, 1, 1, 14, 1, 0, 0, 0),     8'h00);
    add(mk(1, 14, 1, 1, 1, 15, 1, 0, 0, 0),    8'h00);
    add(mk(1, 2, 2, 1, 1, 16, 1, 0, 0, 1),     8'hC4);
    add(mk(1, 2, 2, 1, 1, 16, 1, 0, 0, 1),     8'hC4);
    add(mk(1, 2, 2, 1, 1, 16, 1, 0, 0, 1),     8'hC4);
    add(mk(1, 2, 2, 1, 1, 16, 1, 0, 0, 0),     8'h04);
    add(idle,                                  8'h00);

    drive(idle);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].in);
      @(negedge clk);
      check($sformatf("vec%0d", i), tbl[i].exp);
      @(posedge clk); #1;
    end

    // Asynchronous reset in the middle of a load-use stall
    drive(mk(1, 1, 0, 1, 0, 17, 1, 1, 0, 0));
    @(posedge clk); #1;
    drive(mk(1, 17, 0, 1, 0, 18, 1, 0, 0, 0));
    @(negedge clk);
    check("pre_reset_stall", 8'hD0);
    #1 rst_n = 1'b0;
    #1 check("async_reset_outputs", 8'h00);
`ifdef PIPE_HAZARD_PERF_EN
    total++;
    if (perf_stall !== '0 || perf_flush !== '0) begin
      bad++;
      $display("FAIL perf_reset: got %0d/%0d want 0/0", perf_stall, perf_flush);
    end
`endif
    drive(idle);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int s = 0; s < FwdDepth; s++) m_pipe[s] = '0;
    m_src[0] = '0; m_src[1] = '0; m_used[0] = 1'b0; m_used[1] = 1'b0;
    m_flush_left = 0; m_stall_cnt = 0; m_flush_cnt = 0;

    for (int i = 0; i < NumRand; i++) begin
      x = mk($urandom_range(99) < 80, $urandom_range(7), $urandom_range(7),
             1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(7),
             $urandom_range(99) < 75, $urandom_range(99) < 35,
             $urandom_range(99) < 10, $urandom_range(99) < 15);
      drive(x);
      @(negedge clk);
      check($sformatf("rand%0d", i), m_expect(x));
      @(posedge clk);
      m_step(x);
      #1;
    end

`ifdef PIPE_HAZARD_PERF_EN
    @(negedge clk);
    total++;
    if (perf_stall !== XLen'(m_stall_cnt)) begin
      bad++;
      $display("FAIL perf_stall: got %0d want %0d", perf_stall, m_stall_cnt);
    end
    total++;
    if (perf_flush !== XLen'(m_flush_cnt)) begin
      bad++;
      $display("FAIL perf_flush: got %0d want %0d", perf_flush, m_flush_cnt);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
Sequential hazard and forwarding controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB). It tracks destination registers of in-flight instructions in a per-stage record shift chain. It generates per-operand forward selects for the EX stage, load-use stalls, redirect flushes with a configurable flush window, and global freeze on data-memory wait. It sits beside pipe_controller: it consumes decoded ID fields and drives pipeline-register enables and flushes.

Parameters:
X_LEN, 32, datapath width (only affects optional perf counters)
REG_ADDR_W, 5, register address width
FWD_DEPTH, 3, tracked stages after ID: 2 = EX,MEM (no WB forwarding, regfile write-through); 3 = EX,MEM,WB
FLUSH_SLOTS, 1, cycles ID/IF are flushed after a redirect (1..3)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
id_valid_i  in  1  ID holds a valid instruction
id_rs1_addr_i  in  REG_ADDR_W  ID source 1
id_rs2_addr_i  in  REG_ADDR_W  ID source 2
id_rs1_used_i  in  1  instruction reads rs1
id_rs2_used_i  in  1  instruction reads rs2
id_rd_addr_i  in  REG_ADDR_W  ID destination
id_reg_write_i  in  1  instruction writes rd
id_is_load_i  in  1  instruction is a load
ex_redirect_i  in  1  branch taken / JAL / JALR resolved in EX
mem_wait_i  in  1  data memory not ready; freeze the whole pipe
stall_if_o  out  1  hold PC
stall_id_o  out  1  hold IF/ID register
flush_id_o  out  1  clear IF/ID register
bubble_ex_o  out  1  load NOP into ID/EX register
fwd_a_o  out  2  EX rs1 select: 00 regfile, 01 MEM, 10 WB, 11 reserved
fwd_b_o  out  2  EX rs2 select, same encoding

Behaviour:
- Stage record = {valid, rd, reg_write, is_load}; rd==0 forces reg_write=0 on capture. Chain rec[0]=EX, rec[1]=MEM, rec[2]=WB (rec[2] absent when FWD_DEPTH=2). EX also holds registered rs1/rs2 addr+used.
- Reset: all records invalid, flush counter 0. Outputs: stall_*=0, flush_id_o=0, bubble_ex_o=0, fwd_*=00.
- Load-use (comb): id_valid_i & rec[0].valid & rec[0].is_load & rec[0].reg_write & ((rs1_used & rs1==rec[0].rd) | (rs2_used & rs2==rec[0].rd)). Asserts stall_if_o, stall_id_o, bubble_ex_o. Exactly one cycle per hazard.
- Forwarding (comb, EX operands): match rec[1] (MEM) first, then rec[2] (WB). Requires valid & reg_write & used & equal addr. Source addr 0 -> 00. MEM beats WB on double match.
- Redirect: ex_redirect_i asserts flush_id_o and bubble_ex_o the same cycle and loads flush counter with FLUSH_SLOTS-1. flush_id_o stays high while counter>0 (decrements each unfrozen cycle). Redirect overrides load-use stall: stall_* forced 0. A new redirect during the window reloads the counter.
- Clock edge, mem_wait_i=0: rec[0] <= bubble (invalid) if bubble_ex_o or !id_valid_i, else ID record. rec[k] <= rec[k-1].
- mem_wait_i=1: all records, EX sources and the counter hold. stall_if_o=stall_id_o=1. flush_id_o=bubble_ex_o=0. fwd_* still computed from held state. Redirect or load-use coincident with mem_wait_i is re-evaluated on the first unfrozen cycle (inputs held by pipe).
- Reset mid-operation clears chain and counter asynchronously. Outputs go to reset values without a clock.

Optional Feature:
PIPE_HAZARD_PERF_EN: adds perf_stall_cnt_o and perf_flush_cnt_o (X_LEN, saturating at all-ones, reset 0). They count load-use stall cycles and redirect events. Without the macro these ports do not exist and no counter logic is built.

Decomposition:
- Package pipe_pkg: stage_rec_t struct, fwd_sel_e enum (FWD_RF, FWD_MEM, FWD_WB), REG_ADDR_W constant.
- Sub-module pipe_fwd_sel: one operand's priority compare over the record chain, instantiated twice.

Test Plan:
- add x5,x1,x2 then sub x6,x5,x3 -> second in EX: fwd_a_o=01. Next-but-one consumer sees fwd=10 (FWD_DEPTH=3) or 00 (FWD_DEPTH=2).
- lw x7,0(x1) then add x8,x7,x7 -> one cycle stall_if/id=1, bubble_ex_o=1. Then fwd_a_o=fwd_b_o=01 from MEM.
- addi x0,x0,5 then add x9,x0,x0 -> fwd stays 00. lw x0 followed by user -> no stall.
- Load-use and ex_redirect_i same cycle, FLUSH_SLOTS=2 -> stall_*=0, flush_id_o high 2 cycles, bubble_ex_o 1 cycle.
- mem_wait_i high 3 cycles with MEM-forward pending -> chain frozen, stall_*=1, fwd_a_o holds 01. Resume advances normally.
- Deassert rst_ni mid-stall -> all outputs 0 immediately. Perf counters (if enabled) read 0.
